// File: rtl/adder_result_accumulator.sv
// -----------------------------------------------------------------------------
// adder_result_accumulator
//
// Purpose:
//   Sits directly downstream of a 4-bit ripple-carry adder and sums the per-beat
//   result {cout, s} over a frame of BEATS accepted beats. A frame can also be
//   closed early by a flush. Each frame total is offered on a valid/ready port.
//
// Parameters:
//   IN_W   width of the adder sum bits; a beat value is {in_cout, in_sum}
//   ACC_W  accumulator and result width (must be >= IN_W+1)
//   BEATS  accepted beats per full frame (must be >= 1)
//   CNT_W  derived beat-counter width, $clog2(BEATS+1)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   beat present on in_sum/in_cout
//   in_ready   block accepts a beat this cycle (depends on state only)
//   in_sum     adder sum bits
//   in_cout    adder carry-out
//   flush      close the current frame early (ignored if it would be empty)
//   out_valid  out_total/out_ovf/out_beats hold a frame result
//   out_ready  downstream accepts the result
//   out_total  frame total
//   out_ovf    total carried out of ACC_W bits during the frame
//   out_beats  number of beats summed into out_total
//
// Configuration macro:
//   ACC_RESULT_SATURATE_EN  when defined, the accumulator clamps to all-ones on
//                           the first carry out of ACC_W and stays there for the
//                           rest of the frame. When undefined it wraps modulo
//                           2^ACC_W. out_ovf is reported in both builds.
// -----------------------------------------------------------------------------
module adder_result_accumulator #(
  parameter  int unsigned IN_W  = 4,
  parameter  int unsigned ACC_W = 12,
  parameter  int unsigned BEATS = 4,
  localparam int unsigned CNT_W = $clog2(BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_cout,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_beats
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic             ovf_out_q, ovf_out_d;
  logic [CNT_W-1:0] beats_q, beats_d;

  logic             accept;
  logic [ACC_W-1:0] beat_val;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] acc_upd;
  logic             ovf_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             frame_end;

  // Handshake outputs are decoded from the state register alone, so there is
  // no combinational path from out_ready or in_valid to in_ready.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign out_total = total_q;
  assign out_ovf   = ovf_out_q;
  assign out_beats = beats_q;

  assign accept = in_valid & in_ready;

  // Zero-extend the beat. Written as a default plus a slice so that it also
  // elaborates when ACC_W == IN_W+1 (a zero-width replication would not).
  always_comb begin
    beat_val           = '0;
    beat_val[IN_W:0]   = {in_cout, in_sum};
  end

  // One extra bit catches the carry out of the accumulator.
  assign sum_wide = {1'b0, acc_q} + {1'b0, beat_val};

  // Accumulator and overflow value after this cycle's beat (if any).
  always_comb begin
    acc_upd = acc_q;
    ovf_upd = ovf_acc_q;
    if (accept) begin
      ovf_upd = ovf_acc_q | sum_wide[ACC_W];
`ifdef ACC_RESULT_SATURATE_EN
      // Once saturated the accumulator is pinned at all-ones; any further
      // non-zero beat carries out again, and ovf_upd stays set regardless.
      acc_upd = ovf_upd ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
      acc_upd = sum_wide[ACC_W-1:0];
`endif
    end
  end

  assign cnt_upd = cnt_q + CNT_W'(accept);

  // A flush only closes a frame that would contain at least one beat,
  // counting a beat accepted on the same edge. A flush that coincides with
  // the final beat produces a single frame end.
  assign frame_end = (state_q == ST_ACCUM) &&
                     ((accept && (cnt_q == CNT_W'(BEATS - 1))) ||
                      (flush && ((cnt_q != '0) || accept)));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    total_d   = total_q;
    ovf_out_d = ovf_out_q;
    beats_d   = beats_q;

    unique case (state_q)
      ST_ACCUM: begin
        if (frame_end) begin
          total_d   = acc_upd;
          ovf_out_d = ovf_upd;
          beats_d   = cnt_upd;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
          state_d   = ST_HOLD;
        end else begin
          acc_d     = acc_upd;
          cnt_d     = cnt_upd;
          ovf_acc_d = ovf_upd;
        end
      end
      ST_HOLD: begin
        // Result registers keep their values after the handshake; only
        // out_valid drops.
        if (out_ready) begin
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      total_q   <= '0;
      ovf_out_q <= 1'b0;
      beats_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      total_q   <= total_d;
      ovf_out_q <= ovf_out_d;
      beats_q   <= beats_d;
    end
  end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// -----------------------------------------------------------------------------
// tb_adder_result_accumulator
//
// Two instances share every input: dut_a uses the default widths (ACC_W=12),
// dut_b uses ACC_W=5 so that overflow is reachable. Directed vectors come from
// a table; multi-cycle corners are hand sequences; a long randomized run is
// compared against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_adder_result_accumulator;

`ifdef ACC_RESULT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int BEATS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_sum;
  logic        in_cout;
  logic        flush;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [11:0] out_total_a;
  logic [2:0]  out_beats_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [4:0]  out_total_b;
  logic [2:0]  out_beats_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adder_result_accumulator #(.IN_W(4), .ACC_W(12), .BEATS(BEATS)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sum(in_sum), .in_cout(in_cout), .flush(flush),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_total(out_total_a), .out_ovf(out_ovf_a), .out_beats(out_beats_a)
  );

  adder_result_accumulator #(.IN_W(4), .ACC_W(5), .BEATS(BEATS)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sum(in_sum), .in_cout(in_cout), .flush(flush),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_total(out_total_b), .out_ovf(out_ovf_b), .out_beats(out_beats_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level reference model: collects beat values in a queue and, when a
  // frame closes, derives the result from the plain integer sum.
  // ---------------------------------------------------------------------------
  int unsigned mq[$];
  bit          m_pend;
  int          m_tot[2];
  bit          m_ovf[2];
  int          m_beats;
  int          frames;
  localparam int WID[2] = '{12, 5};

  function automatic void model_step();
    int unsigned s;
    int unsigned lim;
    if (rst) begin
      mq.delete();
      m_pend  = 1'b0;
      m_tot   = '{0, 0};
      m_ovf   = '{1'b0, 1'b0};
      m_beats = 0;
    end else if (!m_pend) begin
      if (in_valid) mq.push_back({27'd0, in_cout, in_sum});
      if ((in_valid && mq.size() == BEATS) || (flush && mq.size() > 0)) begin
        s = 0;
        foreach (mq[k]) s += mq[k];
        for (int d = 0; d < 2; d++) begin
          lim      = 32'd1 << WID[d];
          m_ovf[d] = (s >= lim);
          m_tot[d] = SAT ? ((s >= lim) ? int'(lim - 1) : int'(s)) : int'(s % lim);
        end
        m_beats = mq.size();
        m_pend  = 1'b1;
        mq.delete();
      end
    end else if (out_ready) begin
      m_pend = 1'b0;
      frames++;
      $display("[TB] frame %0d beats=%0d total12=%0d total5=%0d ovf12=%0d ovf5=%0d",
               frames, m_beats, m_tot[0], m_tot[1], m_ovf[0], m_ovf[1]);
    end
  endfunction

  // Inputs are held across the rising edge; outputs are sampled on the
  // falling edge that follows.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, int'(out_valid_a), int'(m_pend));
    chk({tag, ".in_ready"},  int'(in_ready_a),  int'(!m_pend));
    chk({tag, ".total12"},   int'(out_total_a), m_tot[0]);
    chk({tag, ".ovf12"},     int'(out_ovf_a),   int'(m_ovf[0]));
    chk({tag, ".beats12"},   int'(out_beats_a), m_beats);
    chk({tag, ".out_valid5"},int'(out_valid_b), int'(m_pend));
    chk({tag, ".total5"},    int'(out_total_b), m_tot[1]);
    chk({tag, ".ovf5"},      int'(out_ovf_b),   int'(m_ovf[1]));
    chk({tag, ".beats5"},    int'(out_beats_b), m_beats);
  endtask

  task automatic drive(input bit v, input bit [4:0] val, input bit fl, input bit ordy);
    in_valid  = v;
    {in_cout, in_sum} = val;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic check_a(input string tag, input bit ov, input bit ir,
                         input int tot, input bit ovf, input int beats);
    chk({tag, ".out_valid"}, int'(out_valid_a), int'(ov));
    chk({tag, ".in_ready"},  int'(in_ready_a),  int'(ir));
    chk({tag, ".total"},     int'(out_total_a), tot);
    chk({tag, ".ovf"},       int'(out_ovf_a),   int'(ovf));
    chk({tag, ".beats"},     int'(out_beats_a), beats);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table for dut_a: inputs applied for one edge, outputs
  // expected just after that edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit       v;
    bit [4:0] val;
    bit       fl;
    bit       ordy;
    bit       e_ov;
    bit       e_ir;
    int       e_tot;
    bit       e_ovf;
    int       e_beats;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(bit v, bit [4:0] val, bit fl, bit ordy,
                              bit e_ov, bit e_ir, int e_tot, bit e_ovf, int e_beats);
    vec_t r;
    r = '{v, val, fl, ordy, e_ov, e_ir, e_tot, e_ovf, e_beats};
    tbl.push_back(r);
  endfunction

  initial begin
    int cyc;

    // Basic frame: 5 + 7 + 16 + 15 = 43, result visible right after beat 4.
    row(1, 5'b0_0101, 0, 1,  0, 1,  0, 0, 0);
    row(1, 5'b0_0111, 0, 1,  0, 1,  0, 0, 0);
    row(1, 5'b1_0000, 0, 1,  0, 1,  0, 0, 0);
    row(1, 5'b0_1111, 0, 1,  1, 0, 43, 0, 4);
    row(0, 5'd0,      0, 1,  0, 1, 43, 0, 4);
    // Backpressure: result held for 3 cycles; beats and flush in HOLD ignored.
    row(1, 5'b0_0101, 0, 0,  0, 1, 43, 0, 4);
    row(1, 5'b0_0111, 0, 0,  0, 1, 43, 0, 4);
    row(1, 5'b1_0000, 0, 0,  0, 1, 43, 0, 4);
    row(1, 5'b0_1111, 0, 0,  1, 0, 43, 0, 4);
    row(1, 5'd3,      0, 0,  1, 0, 43, 0, 4);
    row(0, 5'd0,      1, 0,  1, 0, 43, 0, 4);
    row(0, 5'd0,      0, 0,  1, 0, 43, 0, 4);
    row(0, 5'd0,      0, 1,  0, 1, 43, 0, 4);
    // Early flush after two beats: 3 + 4 = 7.
    row(1, 5'd3,      0, 1,  0, 1, 43, 0, 4);
    row(1, 5'd4,      0, 1,  0, 1, 43, 0, 4);
    row(0, 5'd0,      1, 1,  1, 0,  7, 0, 2);
    row(0, 5'd0,      0, 1,  0, 1,  7, 0, 2);
    // Flush on an empty frame is ignored.
    row(0, 5'd0,      1, 1,  0, 1,  7, 0, 2);
    row(0, 5'd0,      0, 1,  0, 1,  7, 0, 2);
    // Flush together with a single beat.
    row(1, 5'd9,      1, 1,  1, 0,  9, 0, 1);
    row(0, 5'd0,      0, 1,  0, 1,  9, 0, 1);
    // Flush together with the final beat: one frame of BEATS beats.
    row(1, 5'd1,      0, 1,  0, 1,  9, 0, 1);
    row(1, 5'd2,      0, 1,  0, 1,  9, 0, 1);
    row(1, 5'd3,      0, 1,  0, 1,  9, 0, 1);
    row(1, 5'd4,      1, 1,  1, 0, 10, 0, 4);
    row(0, 5'd0,      0, 1,  0, 1, 10, 0, 4);

    frames = 0;
    rst = 1'b1;
    drive(0, 5'd0, 0, 1);
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    check_a("reset", 0, 1, 0, 0, 0);
    chk("reset.total5", int'(out_total_b), 0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].val, tbl[i].fl, tbl[i].ordy);
      cycle();
      check_a($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_ir,
              tbl[i].e_tot, tbl[i].e_ovf, tbl[i].e_beats);
    end

    // Reset mid-frame discards the partial sum; previous result is cleared.
    drive(1, 5'd10, 0, 1); cycle();
    drive(1, 5'd10, 0, 1); cycle();
    drive(0, 5'd0,  0, 1); rst = 1'b1; cycle(); rst = 1'b0;
    check_a("midrst", 0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'd1, 0, 1);
      cycle();
    end
    check_a("afterrst", 1, 0, 4, 0, 4);
    drive(0, 5'd0, 0, 1); cycle();

    // Overflow: 20 + 20 + 0 + 0 = 40, past 5 bits on dut_b.
    drive(1, 5'd20, 0, 1); cycle();
    drive(1, 5'd20, 0, 1); cycle();
    drive(1, 5'd0,  0, 1); cycle();
    drive(1, 5'd0,  0, 1); cycle();
    check_a("ovf12", 1, 0, 40, 0, 4);
    chk("ovf5.out_valid", int'(out_valid_b), 1);
    chk("ovf5.total",     int'(out_total_b), SAT ? 31 : 8);
    chk("ovf5.ovf",       int'(out_ovf_b),   1);
    chk("ovf5.beats",     int'(out_beats_b), 4);
    drive(0, 5'd0, 0, 1); cycle();
    // Next frame starts clean: no sticky overflow carried over.
    drive(1, 5'd2, 1, 1); cycle();
    chk("ovf5.clear.total", int'(out_total_b), 2);
    chk("ovf5.clear.ovf",   int'(out_ovf_b),   0);
    drive(0, 5'd0, 0, 1); cycle();

    // Randomized run against the reference model (model is in sync here).
    frames = 0;
    cyc    = 0;
    check_model("sync");
    while (frames < 1000 && cyc < 40000) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
      cycle();
      check_model($sformatf("rnd%0d", cyc));
      cyc++;
    end
    if (frames < 1000) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL random_budget: got %0d frames, expected 1000", frames);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
